// File: rtl/sdram_pkg.sv
// Shared definitions for the 32-bit bus to 16-bit SDRAM host-port bridge.
package sdram_pkg;

    // Bridge sequencing states.
    typedef enum logic [2:0] {
        WAIT_CFG = 3'd0,
        IDLE     = 3'd1,
        LO       = 3'd2,
        HI       = 3'd3,
        DONE     = 3'd4
    } bridge_state_t;

    // Default wait budget for one halfword completion, in clk cycles.
    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    // Width of the halfword timeout counter.
    localparam int CNT_WIDTH = 8;

    // Halfword address on the controller side: the word address with the
    // halfword select in bit 1 and bit 0 always clear.
    function automatic logic [31:0] half_addr(input logic [29:0] word_addr,
                                              input logic        upper);
        return {word_addr, upper, 1'b0};
    endfunction

endpackage

// File: rtl/sdram_bus_bridge_counter.sv
// Free-running cycle counter with synchronous clear; saturates at all-ones
// so a long stall never wraps back into a small count.
module sdram_bus_bridge_counter
    import sdram_pkg::*;
#(
    parameter int COUNT_WIDTH = CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] count
);

    // Count cycles since the last clear, holding at the top value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sdram_bus_bridge.sv
// Splits a 32-bit bus access into at most two 16-bit accesses on the SDRAM
// controller host port (lower halfword first), reassembles read data and
// returns a single-cycle ack, flagged with bus_error on a controller stall.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   WAIT_CFG | controller still initialising; bus requests ignored
//   IDLE     | waiting for bus_access; latches the request on accept
//   LO       | lower halfword (bytes 1:0) presented to the controller
//   HI       | upper halfword (bytes 3:2) presented to the controller
//   DONE     | bus_ack high for this one cycle; bus_access not sampled
module sdram_bus_bridge
    import sdram_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        bus_access,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_wr_en,
    input  logic [3:0]  bus_bytesel,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        bus_error,

    output logic [31:0] h_addr,
    output logic [15:0] h_wdata,
    output logic        h_wr_en,
    output logic [1:0]  h_bytesel,
    input  logic [15:0] h_rdata,
    input  logic        h_compl,
    input  logic        h_config_done
);

    // Last count value seen while still waiting; the following edge is the
    // TIMEOUT_CYCLES-th cycle spent in the halfword state.
    localparam logic [CNT_WIDTH-1:0] TC_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    bridge_state_t        state;

    // Latched request. The lower halfword is issued straight from the bus
    // inputs on accept, so only what the upper halfword needs is held.
    logic [29:0]          acc_addr;
    logic [15:0]          acc_wdata_hi;
    logic                 acc_wr;
    logic [1:0]           acc_bytesel_hi;

    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 wait_clear;
    logic                 timed_out;

    // Byte-lane offset bits carry no meaning for a word-wide request.
    logic [1:0]           unused_addr_lsb;
    assign unused_addr_lsb = bus_addr[1:0];

    // Hold the counter at zero outside the halfword states and restart it on
    // every completion, so each halfword gets a fresh budget from its first cycle.
    always_comb begin
        wait_clear = 1'b1;
        if ((state == LO) || (state == HI)) begin
            wait_clear = h_compl;
        end
    end

    assign timed_out = (wait_cnt == TC_LAST);

    sdram_bus_bridge_counter #(
        .COUNT_WIDTH (CNT_WIDTH)
    ) u_wait_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (wait_clear),
        .count (wait_cnt)
    );

    // Sequencing FSM with all bus-side and controller-side outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= WAIT_CFG;
            acc_addr       <= '0;
            acc_wdata_hi   <= '0;
            acc_wr         <= 1'b0;
            acc_bytesel_hi <= '0;
            h_addr         <= '0;
            h_wdata        <= '0;
            h_wr_en        <= 1'b0;
            h_bytesel      <= '0;
            bus_rdata      <= '0;
            bus_ack        <= 1'b0;
            bus_error      <= 1'b0;
        end else begin
            bus_ack   <= 1'b0;
            bus_error <= 1'b0;

            case (state)
                WAIT_CFG: begin
                    if (h_config_done) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (bus_access) begin
                        acc_addr       <= bus_addr[31:2];
                        acc_wdata_hi   <= bus_wdata[31:16];
                        acc_wr         <= bus_wr_en;
                        acc_bytesel_hi <= bus_bytesel[3:2];
                        if (bus_bytesel[1:0] != 2'b00) begin
                            state     <= LO;
                            h_addr    <= half_addr(bus_addr[31:2], 1'b0);
                            h_wdata   <= bus_wdata[15:0];
                            h_bytesel <= bus_bytesel[1:0];
                            h_wr_en   <= bus_wr_en;
                        end else if (bus_bytesel[3:2] != 2'b00) begin
                            state     <= HI;
                            h_addr    <= half_addr(bus_addr[31:2], 1'b1);
                            h_wdata   <= bus_wdata[31:16];
                            h_bytesel <= bus_bytesel[3:2];
                            h_wr_en   <= bus_wr_en;
                        end else begin
                            // No lanes enabled: acknowledge without touching SDRAM.
                            state   <= DONE;
                            bus_ack <= 1'b1;
                        end
                    end
                end

                LO: begin
                    if (h_compl) begin
                        bus_rdata[15:0] <= h_rdata;
                        if (acc_bytesel_hi != 2'b00) begin
                            state     <= HI;
                            h_addr    <= half_addr(acc_addr, 1'b1);
                            h_wdata   <= acc_wdata_hi;
                            h_bytesel <= acc_bytesel_hi;
                            h_wr_en   <= acc_wr;
                        end else begin
                            // Drop the request on the completion edge so the
                            // controller cannot see it as a new access.
                            state     <= DONE;
                            bus_ack   <= 1'b1;
                            h_bytesel <= '0;
                            h_wr_en   <= 1'b0;
                        end
                    end else if (timed_out) begin
                        state     <= DONE;
                        bus_ack   <= 1'b1;
                        bus_error <= 1'b1;
                        h_bytesel <= '0;
                        h_wr_en   <= 1'b0;
                    end
                end

                HI: begin
                    if (h_compl) begin
                        bus_rdata[31:16] <= h_rdata;
                        state            <= DONE;
                        bus_ack          <= 1'b1;
                        h_bytesel        <= '0;
                        h_wr_en          <= 1'b0;
                    end else if (timed_out) begin
                        state     <= DONE;
                        bus_ack   <= 1'b1;
                        bus_error <= 1'b1;
                        h_bytesel <= '0;
                        h_wr_en   <= 1'b0;
                    end
                end

                DONE: begin
                    // bus_ack drops here; a held bus_access is taken next cycle.
                    state <= IDLE;
                end

                default: begin
                    state     <= WAIT_CFG;
                    h_bytesel <= '0;
                    h_wr_en   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_bus_bridge.sv
// Directed bench for sdram_bus_bridge with a small SDRAM host-port model.
module tb_sdram_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_access;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_wr_en;
    logic [3:0]  bus_bytesel;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_error;
    logic [31:0] h_addr;
    logic [15:0] h_wdata;
    logic        h_wr_en;
    logic [1:0]  h_bytesel;
    logic [15:0] h_rdata;
    logic        h_compl;
    logic        h_config_done;

    logic        model_compl;
    logic        stray_compl;
    assign h_compl = model_compl | stray_compl;

    int          n_cmp;
    int          n_err;

    // Controller model knobs and request log.
    int          ctl_lat;
    bit          ctl_respond;
    logic [15:0] lo_val;
    logic [15:0] hi_val;
    int          lat_cnt;
    logic [31:0] log_addr[$];
    logic [15:0] log_wdata[$];
    logic [1:0]  log_bs[$];
    logic        log_wr[$];

    always #5 clk = ~clk;

    sdram_bus_bridge #(
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_access    (bus_access),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wr_en     (bus_wr_en),
        .bus_bytesel   (bus_bytesel),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack),
        .bus_error     (bus_error),
        .h_addr        (h_addr),
        .h_wdata       (h_wdata),
        .h_wr_en       (h_wr_en),
        .h_bytesel     (h_bytesel),
        .h_rdata       (h_rdata),
        .h_compl       (h_compl),
        .h_config_done (h_config_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_wdata.delete();
        log_bs.delete();
        log_wr.delete();
    endtask

    // Host-port model: a request is any cycle with h_bytesel != 0; it logs the
    // request on its first cycle and pulses h_compl after ctl_lat wait cycles.
    initial begin
        model_compl = 1'b0;
        h_rdata     = '0;
        lat_cnt     = 0;
        forever begin
            @(posedge clk);
            #2;
            model_compl = 1'b0;
            if (rst_n && h_bytesel != 2'b00) begin
                if (lat_cnt == 0) begin
                    log_addr.push_back(h_addr);
                    log_wdata.push_back(h_wdata);
                    log_bs.push_back(h_bytesel);
                    log_wr.push_back(h_wr_en);
                end
                if (ctl_respond && lat_cnt >= ctl_lat) begin
                    model_compl = 1'b1;
                    h_rdata     = h_addr[1] ? hi_val : lo_val;
                    lat_cnt     = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // One bus transaction, started from a sample point (#1 after posedge) with
    // the DUT in IDLE. edges = posedges until ack seen, hb = cycles with h_bytesel != 0.
    task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic wr,
                            input logic [3:0] bs, input bit hold,
                            output logic [31:0] rd, output logic err,
                            output int edges, output int hb);
        bit got;
        got   = 1'b0;
        edges = 0;
        hb    = 0;
        rd    = '0;
        err   = 1'b0;
        bus_addr    = a;
        bus_wdata   = d;
        bus_wr_en   = wr;
        bus_bytesel = bs;
        bus_access  = 1'b1;
        while (!got && edges < 1000) begin
            @(posedge clk);
            #1;
            edges++;
            if (h_bytesel != 2'b00) hb++;
            if (bus_ack) begin
                got = 1'b1;
                rd  = bus_rdata;
                err = bus_error;
            end
        end
        check_eq("ack_seen", 32'(got), 32'h1);
        if (!hold) begin
            bus_access = 1'b0;
            @(posedge clk);
            #1;
            check_eq("ack_single", 32'(bus_ack), 32'h0);
            check_eq("err_after_done", 32'(bus_error), 32'h0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          edges;
        int          hb;
        int          activity;
        bit          found;

        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus_access    = 1'b0;
        bus_addr      = '0;
        bus_wdata     = '0;
        bus_wr_en     = 1'b0;
        bus_bytesel   = '0;
        h_config_done = 1'b0;
        stray_compl   = 1'b0;
        ctl_lat       = 2;
        ctl_respond   = 1'b1;
        lo_val        = '0;
        hi_val        = '0;

        // Reset values, then bus requests ignored until config done.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_h_bytesel", 32'(h_bytesel), 32'h0);
        check_eq("rst_h_addr", h_addr, 32'h0);
        check_eq("rst_bus_rdata", bus_rdata, 32'h0);
        check_eq("rst_bus_ack", 32'(bus_ack), 32'h0);
        check_eq("rst_bus_error", 32'(bus_error), 32'h0);
        rst_n       = 1'b1;
        bus_access  = 1'b1;
        bus_bytesel = 4'hF;
        activity    = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus_ack || h_bytesel != 2'b00) activity++;
        end
        check_eq("wait_cfg_ignore", activity, 0);
        bus_access    = 1'b0;
        h_config_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full-word read: lower then upper halfword, 1 + 3 + 3 edges to ack.
        clear_log();
        lo_val = 16'h1234;
        hi_val = 16'hABCD;
        bus_xfer(32'h0000_0100, 32'h0, 1'b0, 4'hF, 1'b0, rd, err, edges, hb);
        check_eq("rd32_data", rd, 32'hABCD_1234);
        check_eq("rd32_err", 32'(err), 32'h0);
        check_eq("rd32_edges", edges, 7);
        check_eq("rd32_nreq", log_addr.size(), 2);
        check_eq("rd32_addr_lo", log_addr[0], 32'h0000_0100);
        check_eq("rd32_addr_hi", log_addr[1], 32'h0000_0102);
        check_eq("rd32_bs_lo", 32'(log_bs[0]), 32'h3);
        check_eq("rd32_bs_hi", 32'(log_bs[1]), 32'h3);

        // Lower-only read keeps the upper half from the previous access.
        clear_log();
        lo_val = 16'h5555;
        bus_xfer(32'h0000_0300, 32'h0, 1'b0, 4'b0011, 1'b0, rd, err, edges, hb);
        check_eq("rdlo_data", rd, 32'hABCD_5555);
        check_eq("rdlo_edges", edges, 4);
        check_eq("rdlo_nreq", log_addr.size(), 1);

        // Upper-only read (byte 2) keeps the lower half.
        clear_log();
        hi_val = 16'h7777;
        bus_xfer(32'h0000_0305, 32'h0, 1'b0, 4'b0100, 1'b0, rd, err, edges, hb);
        check_eq("rdhi_data", rd, 32'h7777_5555);
        check_eq("rdhi_addr", log_addr[0], 32'h0000_0306);
        check_eq("rdhi_bs", 32'(log_bs[0]), 32'h1);

        // Upper-only write: one HI request carrying the top halfword.
        clear_log();
        bus_xfer(32'h0000_0200, 32'hDEAD_BEEF, 1'b1, 4'b1100, 1'b0, rd, err, edges, hb);
        check_eq("wrhi_nreq", log_addr.size(), 1);
        check_eq("wrhi_addr", log_addr[0], 32'h0000_0202);
        check_eq("wrhi_wdata", 32'(log_wdata[0]), 32'h0000_DEAD);
        check_eq("wrhi_bs", 32'(log_bs[0]), 32'h3);
        check_eq("wrhi_wr", 32'(log_wr[0]), 32'h1);
        check_eq("wrhi_err", 32'(err), 32'h0);
        check_eq("wrhi_hbs_idle", 32'(h_bytesel), 32'h0);

        // Lower-only write carries the bottom halfword.
        clear_log();
        bus_xfer(32'h0000_0400, 32'h1234_5678, 1'b1, 4'b0001, 1'b0, rd, err, edges, hb);
        check_eq("wrlo_addr", log_addr[0], 32'h0000_0400);
        check_eq("wrlo_wdata", 32'(log_wdata[0]), 32'h0000_5678);
        check_eq("wrlo_bs", 32'(log_bs[0]), 32'h1);

        // Zero byte enables: ack on the edge after accept (access + DONE cycle), no traffic.
        clear_log();
        bus_xfer(32'h0000_0500, 32'h0, 1'b0, 4'b0000, 1'b0, rd, err, edges, hb);
        check_eq("zero_edges", edges, 1);
        check_eq("zero_hb_cycles", hb, 0);
        check_eq("zero_nreq", log_addr.size(), 0);
        check_eq("zero_err", 32'(err), 32'h0);

        // Held bus_access: DONE holdoff, then re-accept; stray compl in IDLE ignored.
        bus_xfer(32'h0000_0500, 32'h0, 1'b0, 4'b0000, 1'b1, rd, err, edges, hb);
        @(posedge clk);
        #1;
        check_eq("hold_holdoff_ack", 32'(bus_ack), 32'h0);
        @(posedge clk);
        #1;
        check_eq("hold_reaccept_ack", 32'(bus_ack), 32'h1);
        bus_access = 1'b0;
        @(posedge clk);
        #1;
        check_eq("hold_release_ack", 32'(bus_ack), 32'h0);
        stray_compl = 1'b1;
        @(posedge clk);
        #1;
        stray_compl = 1'b0;
        activity    = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus_ack || h_bytesel != 2'b00) activity++;
        end
        check_eq("stray_idle_compl", activity, 0);

        // Controller never completes: error ack after 255 cycles in LO.
        clear_log();
        ctl_respond = 1'b0;
        bus_xfer(32'h0000_0600, 32'h0, 1'b0, 4'b0001, 1'b0, rd, err, edges, hb);
        check_eq("tmo_err", 32'(err), 32'h1);
        check_eq("tmo_lo_cycles", hb, 255);
        check_eq("tmo_edges", edges, 256);
        check_eq("tmo_hbs_after", 32'(h_bytesel), 32'h0);
        ctl_respond = 1'b1;
        lo_val = 16'h0F0F;
        bus_xfer(32'h0000_0600, 32'h0, 1'b0, 4'b0001, 1'b0, rd, err, edges, hb);
        check_eq("post_tmo_data", rd, 32'h7777_0F0F);
        check_eq("post_tmo_err", 32'(err), 32'h0);

        // Reset during HI: immediate reset values, no ack, wait for config.
        ctl_lat     = 10;
        bus_addr    = 32'h0000_0700;
        bus_wdata   = 32'h0;
        bus_wr_en   = 1'b0;
        bus_bytesel = 4'hF;
        bus_access  = 1'b1;
        found       = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (h_bytesel != 2'b00 && h_addr[1]) found = 1'b1;
        end
        check_eq("rst_reached_hi", 32'(found), 32'h1);
        h_config_done = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_h_bytesel", 32'(h_bytesel), 32'h0);
        check_eq("arst_h_addr", h_addr, 32'h0);
        check_eq("arst_h_wdata", 32'(h_wdata), 32'h0);
        check_eq("arst_h_wr_en", 32'(h_wr_en), 32'h0);
        check_eq("arst_bus_rdata", bus_rdata, 32'h0);
        check_eq("arst_bus_ack", 32'(bus_ack), 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        activity = 0;
        for (int i = 0; i < 6; i++) begin
            stray_compl = (i == 2);
            @(posedge clk);
            #1;
            if (bus_ack || h_bytesel != 2'b00) activity++;
        end
        stray_compl = 1'b0;
        check_eq("arst_wait_cfg", activity, 0);
        bus_access    = 1'b0;
        h_config_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ctl_lat = 1;
        lo_val  = 16'h1111;
        hi_val  = 16'h2222;
        bus_xfer(32'h0000_0800, 32'h0, 1'b0, 4'hF, 1'b0, rd, err, edges, hb);
        check_eq("arst_after_data", rd, 32'h2222_1111);
        check_eq("arst_after_edges", edges, 5);
        check_eq("arst_after_err", 32'(err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
